// File: rtl/dae_output_serializer_if.sv
// Frame-in / sample-out bus between the DAE core, this serializer and the DAC path.
// master drives frames, gain and out_ready; slave is the serializer itself.
interface dae_output_serializer_if #(
  parameter int FRAME_DEPTH = 4,
  parameter int SAMPLE_W    = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [SAMPLE_W-1:0]    clean_signal0;
  logic signed [SAMPLE_W-1:0]    clean_signal1;
  logic signed [SAMPLE_W-1:0]    clean_signal2;
  logic signed [SAMPLE_W-1:0]    clean_signal3;
  logic [3:0]                    gain;
  logic signed [SAMPLE_W-1:0]    out_sample;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic                          drop_sticky;
  logic [$clog2(FRAME_DEPTH):0]  frame_count;

  modport master (
    output in_valid, clean_signal0, clean_signal1, clean_signal2, clean_signal3,
           gain, out_ready,
    input  in_ready, out_sample, out_valid, out_last, drop_sticky, frame_count
  );

  modport slave (
    input  in_valid, clean_signal0, clean_signal1, clean_signal2, clean_signal3,
           gain, out_ready,
    output in_ready, out_sample, out_valid, out_last, drop_sticky, frame_count
  );
endinterface

// File: rtl/dae_output_serializer.sv
// Buffers 4-sample DAE frames in a small FIFO and streams them out one gained,
// saturated sample per beat, with a sticky flag for frames refused while full.
module dae_output_serializer #(
  parameter int FRAME_DEPTH = 4,
  parameter int SAMPLE_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dae_output_serializer_if.slave bus
);
  localparam int AW = $clog2(FRAME_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 4 * SAMPLE_W;
  localparam int PW = SAMPLE_W + 5;
  localparam logic signed [PW-1:0] PMAX = {{6{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{6{1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_t;

  logic [FW-1:0]              mem [FRAME_DEPTH];
  logic [AW-1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]              count_reg, count_next;
  state_t                     state_reg, state_next;
  logic [1:0]                 idx_reg, idx_next;
  logic [FW-1:0]              frame_reg, frame_next;
  logic [3:0]                 gain_reg, gain_next;
  logic signed [SAMPLE_W-1:0] out_sample_reg, out_sample_next;
  logic                       out_valid_reg, out_valid_next;
  logic                       out_last_reg, out_last_next;
  logic                       drop_reg;

  logic [FW-1:0]              in_frame, head_frame;
  logic signed [SAMPLE_W-1:0] head_s  [4];
  logic signed [SAMPLE_W-1:0] frame_s [4];
  logic                       in_ready_int, wr_en, pop;

  // Q2.2 gain: full product, floor-shift by 2, clamp to the sample range.
  function automatic logic signed [SAMPLE_W-1:0] apply_gain(
    input logic signed [SAMPLE_W-1:0] s,
    input logic [3:0]                 g
  );
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    p = PW'(s) * PW'($signed({1'b0, g}));
    r = p >>> 2;
    if (r > PMAX)      apply_gain = PMAX[SAMPLE_W-1:0];
    else if (r < PMIN) apply_gain = PMIN[SAMPLE_W-1:0];
    else               apply_gain = r[SAMPLE_W-1:0];
  endfunction

  assign in_frame   = {bus.clean_signal3, bus.clean_signal2, bus.clean_signal1, bus.clean_signal0};
  // Head is read combinationally so a pop can load sample 0 on the same edge.
  assign head_frame = mem[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign head_s[gi]  = head_frame[gi*SAMPLE_W +: SAMPLE_W];
      assign frame_s[gi] = frame_reg[gi*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  assign in_ready_int = (count_reg != CW'(FRAME_DEPTH));
  assign wr_en        = bus.in_valid & in_ready_int;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= in_frame;
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    frame_next      = frame_reg;
    gain_next       = gain_reg;
    out_sample_next = out_sample_reg;
    out_valid_next  = out_valid_reg;
    out_last_next   = out_last_reg;
    pop             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (count_reg != '0) pop = 1'b1;
      end
      STREAM: begin
        if (out_valid_reg && bus.out_ready) begin
          if (idx_reg != 2'd3) begin
            idx_next        = idx_reg + 2'd1;
            out_sample_next = apply_gain(frame_s[idx_next], gain_reg);
            out_last_next   = (idx_next == 2'd3);
          end else if (count_reg != '0) begin
            pop = 1'b1;
          end else begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            state_next     = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A pop always starts a fresh frame at sample 0 with the gain present now.
    if (pop) begin
      frame_next      = head_frame;
      gain_next       = bus.gain;
      out_sample_next = apply_gain(head_s[0], bus.gain);
      out_valid_next  = 1'b1;
      out_last_next   = 1'b0;
      idx_next        = 2'd0;
      state_next      = STREAM;
    end

    count_next = count_reg + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      state_reg      <= IDLE;
      idx_reg        <= '0;
      frame_reg      <= '0;
      gain_reg       <= '0;
      out_sample_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg      <= count_next;
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_reg      <= frame_next;
      gain_reg       <= gain_next;
      out_sample_reg <= out_sample_next;
      out_valid_reg  <= out_valid_next;
      out_last_reg   <= out_last_next;
      if (bus.in_valid && !in_ready_int) drop_reg <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_sample  = out_sample_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_last    = out_last_reg;
  assign bus.drop_sticky = drop_reg;
  assign bus.frame_count = count_reg;
endmodule

// File: tb/tb_dae_output_serializer.sv
// Directed + randomized bench for dae_output_serializer; a negedge monitor checks
// every output beat against a queue of expected samples built from the gain rule.
module tb_dae_output_serializer;
  localparam int FD = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dae_output_serializer_if #(.FRAME_DEPTH(FD), .SAMPLE_W(SW)) bus();

  dae_output_serializer #(.FRAME_DEPTH(FD), .SAMPLE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef logic [3:0][SW-1:0] frame_t;
  typedef struct {
    logic signed [SW-1:0] s;
    logic                 last;
  } beat_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  beat_t  exp_q[$];
  bit     mon_en   = 1'b0;
  int     beats    = 0;
  bit     stall    = 1'b0;
  logic signed [SW-1:0] held_s;
  logic   held_l;

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor(sample*gain/4) clamped to the signed sample range.
  function automatic int ref_gain(int s, int g);
    int p, q;
    int hi, lo;
    hi = (1 << (SW - 1)) - 1;
    lo = -(1 << (SW - 1));
    p  = s * g;
    q  = (p >= 0) ? p / 4 : -((-p + 3) / 4);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic frame_t mk(int a, int b, int c, int d);
    frame_t f;
    f[0] = SW'(a); f[1] = SW'(b); f[2] = SW'(c); f[3] = SW'(d);
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < 4; i++) f[i] = SW'($urandom);
    return f;
  endfunction

  task automatic push_expected(frame_t f, int g);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.s    = SW'(ref_gain($signed(f[i]), g));
      b.last = (i == 3);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_frame(frame_t f);
    bus.in_valid      = 1'b1;
    bus.clean_signal0 = f[0];
    bus.clean_signal1 = f[1];
    bus.clean_signal2 = f[2];
    bus.clean_signal3 = f[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, n < 300, 1);
  endtask

  // Single frame into an idle DUT with out_ready high, checked beat by beat.
  task automatic directed_frame(string tag, frame_t f, int g, frame_t e);
    bus.gain      = 4'(g);
    bus.out_ready = 1'b1;
    drive_frame(f);
    push_expected(f, g);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_lat_count"}, bus.frame_count, 1);
    check({tag, "_lat_valid"}, bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
      check($sformatf("%s_sample%0d", tag, i), bus.out_sample, $signed(e[i]));
      check($sformatf("%s_last%0d", tag, i), bus.out_last, (i == 3));
    end
    tick();
    check({tag, "_end_valid"}, bus.out_valid, 0);
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (mon_en && !rst) begin
      if (stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_sample", bus.out_sample, held_s);
        check("hold_last", bus.out_last, held_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        stall = 1'b0;
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat_sample", bus.out_sample, b.s);
          check("beat_last", bus.out_last, b.last);
        end
      end else if (bus.out_valid) begin
        stall  = 1'b1;
        held_s = bus.out_sample;
        held_l = bus.out_last;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f, f0, f1;
    int     g, g_old, g_new, beats0, exp_cnt, n, first_v, last_v, nvalid;
    int     pat [4];
    localparam int NB = 6;
    localparam int KB = 2;

    bus.in_valid = 1'b0; bus.clean_signal0 = '0; bus.clean_signal1 = '0;
    bus.clean_signal2 = '0; bus.clean_signal3 = '0;
    bus.gain = 4'd4; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_drop", bus.drop_sticky, 0);
    check("rst_count", bus.frame_count, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Unity passthrough and saturating gains
    directed_frame("unity", mk(10, -20, 127, -128), 4, mk(10, -20, 127, -128));
    directed_frame("gain2", mk(100, -100, 3, -3), 8, mk(127, -128, 6, -6));
    directed_frame("gainq", mk(7, -7, 0, 1), 1, mk(1, -2, 0, 0));
    $display("directed gain frames done, %0d beats seen", beats);

    // Backpressure with two queued frames
    bus.out_ready = 1'b0;
    g = $urandom_range(1, 15);
    bus.gain = 4'(g);
    f0 = rand_frame(); f1 = rand_frame();
    drive_frame(f0); push_expected(f0, g); tick();
    drive_frame(f1); push_expected(f1, g); tick();
    bus.in_valid = 1'b0;
    tick();
    check("bp_count_initial", bus.frame_count, 1);
    check("bp_valid_initial", bus.out_valid, 1);
    pat = '{1, 0, 0, 1};
    beats0 = beats;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      bus.out_ready = pat[n % 4][0];
      tick();
      exp_cnt = ((beats - beats0) >= 4) ? 0 : 1;
      check($sformatf("bp_count_c%0d", n), bus.frame_count, exp_cnt);
      n++;
    end
    bus.out_ready = 1'b1;
    drain("bp");
    check("bp_beats", beats - beats0, 8);
    $display("backpressure gain=%0d done in %0d cycles", g, n);

    // Overflow: FD+2 frames offered while stalled
    bus.out_ready = 1'b0;
    g = $urandom_range(0, 15);
    bus.gain = 4'(g);
    for (int k = 0; k < FD + 2; k++) begin
      f = rand_frame();
      drive_frame(f);
      check($sformatf("ovf_in_ready%0d", k), bus.in_ready, (k < FD + 1));
      if (k < FD + 1) push_expected(f, g);
      tick();
    end
    bus.in_valid = 1'b0;
    check("ovf_count_full", bus.frame_count, FD);
    check("ovf_in_ready_low", bus.in_ready, 0);
    check("ovf_drop", bus.drop_sticky, 1);
    beats0 = beats;
    bus.out_ready = 1'b1;
    drain("ovf");
    check("ovf_beats", beats - beats0, 4 * (FD + 1));
    check("ovf_drop_held", bus.drop_sticky, 1);
    $display("overflow gain=%0d done, %0d beats", g, beats - beats0);

    // Back-to-back frames, gain change during frame KB
    g_old = $urandom_range(1, 15);
    g_new = (g_old + 5) % 16;
    bus.gain = 4'(g_old);
    bus.out_ready = 1'b1;
    beats0 = beats; first_v = -1; last_v = -1; nvalid = 0;
    for (int c = 0; c < 4 * NB + 8; c++) begin
      if (c % 4 == 0 && c / 4 < NB) begin
        f = rand_frame();
        drive_frame(f);
        check($sformatf("b2b_in_ready%0d", c / 4), bus.in_ready, 1);
        push_expected(f, (c / 4 <= KB) ? g_old : g_new);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (c == 4 * KB + 3) bus.gain = 4'(g_new);
      tick();
      if (bus.out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
    end
    drain("b2b");
    check("b2b_beats", beats - beats0, 4 * NB);
    check("b2b_valid_cycles", nvalid, 4 * NB);
    check("b2b_no_bubble", last_v - first_v + 1, 4 * NB);
    $display("back-to-back gains %0d->%0d done, %0d beats", g_old, g_new, beats - beats0);

    // Asynchronous reset while sample 2 is on the output
    mon_en = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    bus.gain = 4'd4;
    f0 = rand_frame(); f1 = rand_frame();
    drive_frame(f0); tick();
    drive_frame(f1); tick();
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("ar_pre_sample2", bus.out_sample, ref_gain($signed(f0[2]), 4));
    check("ar_pre_count", bus.frame_count, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_last", bus.out_last, 0);
    check("ar_count", bus.frame_count, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_drop", bus.drop_sticky, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    stall = 1'b0;
    mon_en = 1'b1;
    g = $urandom_range(1, 15);
    f = rand_frame();
    bus.gain = 4'(g);
    drive_frame(f);
    push_expected(f, g);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("ar_new_valid", bus.out_valid, 1);
    check("ar_new_sample0", bus.out_sample, ref_gain($signed(f[0]), g));
    check("ar_new_last", bus.out_last, 0);
    drain("ar");
    $display("async reset recovery gain=%0d done", g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
